// File: rtl/matrix_ctrl_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | matrix_ctrl_pkg                                                          |
// | Shared states, opcodes, error codes and sizing helper for matrix_op_ctrl |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package matrix_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    START = 3'd2,
    RUN   = 3'd3,
    SEND  = 3'd4,
    ERR   = 3'd5
  } ctrl_state_e;

  localparam logic [7:0] OP_ADD    = 8'h01;
  localparam logic [7:0] OP_MUL    = 8'h02;
  localparam logic [7:0] OP_BOTH   = 8'h03;

  localparam logic [7:0] ERR_OPC   = 8'hEE;
  localparam logic [7:0] ERR_RUN   = 8'hEF;
  localparam logic [7:0] ERR_RXGAP = 8'hEC;

  function automatic int mat_bytes(input int n, input int dw);
    return (n * n * dw) / 8;
  endfunction

endpackage
`default_nettype wire

// File: rtl/matrix_byte_ser.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | matrix_byte_ser                                                          |
// | Loads a word and emits its top i_nbytes bytes MSB-first over valid/ready |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module matrix_byte_ser #(
  parameter int WORD_W = 256,
  parameter int CNT_W  = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load,
  input  logic [WORD_W-1:0] i_word,
  input  logic [CNT_W-1:0]  i_nbytes,
  input  logic              i_ready,
  output logic [7:0]        o_data,
  output logic              o_valid,
  output logic              o_last
);

  logic [WORD_W-1:0] r_shift;
  logic [CNT_W-1:0]  r_left;
  logic              r_valid;
  logic              w_accept;

  assign w_accept = r_valid && i_ready;
  assign o_last   = w_accept && (r_left == CNT_W'(1));
  assign o_data   = r_shift[WORD_W-1 -: 8];
  assign o_valid  = r_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift <= '0;
      r_left  <= '0;
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_shift <= i_word;
      r_left  <= i_nbytes;
      r_valid <= (i_nbytes != '0);
    end else if (w_accept) begin
      // Next byte is already in the top lane the cycle after acceptance.
      r_shift <= {r_shift[WORD_W-9:0], 8'h00};
      r_left  <= r_left - CNT_W'(1);
      r_valid <= (r_left != CNT_W'(1));
    end
  end

endmodule
`default_nettype wire

// File: rtl/matrix_op_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | matrix_op_ctrl                                                           |
// | Opcode/operand byte sequencer for the 2x2 matrix add/multiply engines.   |
// | Optional: MATRIX_CTRL_RX_TIMEOUT_EN enables the LOAD inter-byte timeout. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module matrix_op_ctrl
  import matrix_ctrl_pkg::*;
#(
  parameter int N           = 2,
  parameter int DW          = 32,
  parameter int RUN_TIMEOUT = 4096,
  parameter int RX_GAP_CYC  = 2_000_000
) (
  input  logic              sys_clk,
  input  logic              rst_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_data_valid,
  output logic [7:0]        tx_data,
  output logic              tx_data_valid,
  input  logic              tx_data_ready,
  output logic [N*N*DW-1:0] mat_a,
  output logic [N*N*DW-1:0] mat_b,
  output logic              op_start,
  output logic [1:0]        op_sel,
  input  logic              add_done,
  input  logic              mul_done,
  input  logic [N*N*DW-1:0] add_res,
  input  logic [N*N*DW-1:0] mul_res,
  output logic              busy,
  output logic              err
);

  localparam int MB     = mat_bytes(N, DW);
  localparam int MAT_W  = N * N * DW;
  localparam int SER_W  = 2 * MAT_W;
  localparam int BCNT_W = $clog2(2 * MB + 1);
  localparam int RCNT_W = $clog2(RUN_TIMEOUT + 1);

  generate
    if ((DW % 8) != 0 || RUN_TIMEOUT < 1 || RX_GAP_CYC < 1) begin : g_param_err
      $error("matrix_op_ctrl: invalid parameter set");
    end
  endgenerate

  ctrl_state_e        r_state;
  ctrl_state_e        w_state_nxt;
  logic [BCNT_W-1:0]  r_byte_cnt;
  logic [RCNT_W-1:0]  r_run_cnt;
  logic               r_add_flag;
  logic               r_mul_flag;
  logic [MAT_W-1:0]   r_mat_a;
  logic [MAT_W-1:0]   r_mat_b;
  logic [MAT_W-1:0]   r_add_res;
  logic [MAT_W-1:0]   r_mul_res;
  logic [1:0]         r_op_sel;
  logic               r_op_start;
  logic               r_busy;
  logic               r_err;

  logic               w_state_chg;
  logic               w_opc_ok;
  logic               w_err_set;
  logic               w_ser_load;
  logic               w_ser_last;
  logic               w_gap_expire;
  logic               w_add_now;
  logic               w_mul_now;
  logic               w_run_done;
  logic [MAT_W-1:0]   w_add_word;
  logic [MAT_W-1:0]   w_mul_word;
  logic [SER_W-1:0]   w_res_word;
  logic [SER_W-1:0]   w_ser_word;
  logic [BCNT_W-1:0]  w_ser_nbytes;

  // A done coinciding with the op_start pulse belongs to a previous launch.
  assign w_add_now  = (r_state == RUN) && add_done && !r_op_start;
  assign w_mul_now  = (r_state == RUN) && mul_done && !r_op_start;
  assign w_run_done = (!r_op_sel[0] || r_add_flag || w_add_now) &&
                      (!r_op_sel[1] || r_mul_flag || w_mul_now);
  assign w_add_word = w_add_now ? add_res : r_add_res;
  assign w_mul_word = w_mul_now ? mul_res : r_mul_res;

  always_comb begin
    w_res_word = {w_add_word, w_mul_word};
    case (r_op_sel)
      2'b01:   w_res_word = {w_add_word, {MAT_W{1'b0}}};
      2'b10:   w_res_word = {w_mul_word, {MAT_W{1'b0}}};
      default: w_res_word = {w_add_word, w_mul_word};
    endcase
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_opc_ok     = 1'b0;
    w_err_set    = 1'b0;
    w_ser_load   = 1'b0;
    w_ser_word   = '0;
    w_ser_nbytes = '0;
    case (r_state)
      IDLE: begin
        if (rx_data_valid) begin
          if (rx_data == OP_ADD || rx_data == OP_MUL || rx_data == OP_BOTH) begin
            w_opc_ok    = 1'b1;
            w_state_nxt = LOAD;
          end else begin
            w_err_set    = 1'b1;
            w_ser_load   = 1'b1;
            w_ser_word   = {ERR_OPC, {(SER_W-8){1'b0}}};
            w_ser_nbytes = BCNT_W'(1);
            w_state_nxt  = ERR;
          end
        end
      end
      LOAD: begin
        if (rx_data_valid && r_byte_cnt == BCNT_W'(2 * MB - 1)) begin
          w_state_nxt = START;
        end else if (w_gap_expire) begin
          w_err_set    = 1'b1;
          w_ser_load   = 1'b1;
          w_ser_word   = {ERR_RXGAP, {(SER_W-8){1'b0}}};
          w_ser_nbytes = BCNT_W'(1);
          w_state_nxt  = ERR;
        end
      end
      START: w_state_nxt = RUN;
      RUN: begin
        // Completion takes priority over a timeout in the same cycle.
        if (w_run_done) begin
          w_ser_load   = 1'b1;
          w_ser_word   = w_res_word;
          w_ser_nbytes = (r_op_sel == 2'b11) ? BCNT_W'(2 * MB) : BCNT_W'(MB);
          w_state_nxt  = SEND;
        end else if (r_run_cnt == RCNT_W'(RUN_TIMEOUT - 1)) begin
          w_err_set    = 1'b1;
          w_ser_load   = 1'b1;
          w_ser_word   = {ERR_RUN, {(SER_W-8){1'b0}}};
          w_ser_nbytes = BCNT_W'(1);
          w_state_nxt  = ERR;
        end
      end
      SEND:    if (w_ser_last) w_state_nxt = IDLE;
      ERR:     if (w_ser_last) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_state_chg = (w_state_nxt != r_state);

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_byte_cnt <= '0;
      r_run_cnt  <= '0;
      r_add_flag <= 1'b0;
      r_mul_flag <= 1'b0;
      r_mat_a    <= '0;
      r_mat_b    <= '0;
      r_add_res  <= '0;
      r_mul_res  <= '0;
      r_op_sel   <= '0;
      r_op_start <= 1'b0;
      r_busy     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_busy     <= (w_state_nxt != IDLE);
      r_err      <= w_err_set;
      r_op_start <= (r_state == START);

      if (w_opc_ok) begin
        r_op_sel <= rx_data[1:0];
        r_mat_a  <= '0;
        r_mat_b  <= '0;
      end else if (r_state == LOAD && rx_data_valid) begin
        for (int i = 0; i < MB; i++) begin
          if (r_byte_cnt == BCNT_W'(i))      r_mat_a[(MB-1-i)*8 +: 8] <= rx_data;
          if (r_byte_cnt == BCNT_W'(MB + i)) r_mat_b[(MB-1-i)*8 +: 8] <= rx_data;
        end
      end

      if (w_state_chg)                              r_byte_cnt <= '0;
      else if (r_state == LOAD && rx_data_valid)    r_byte_cnt <= r_byte_cnt + BCNT_W'(1);

      if (w_state_chg)          r_run_cnt <= '0;
      else if (r_state == RUN)  r_run_cnt <= r_run_cnt + RCNT_W'(1);

      if (w_state_chg) begin
        r_add_flag <= 1'b0;
        r_mul_flag <= 1'b0;
      end else begin
        r_add_flag <= r_add_flag | (w_add_now & r_op_sel[0]);
        r_mul_flag <= r_mul_flag | (w_mul_now & r_op_sel[1]);
      end

      if (w_add_now) r_add_res <= add_res;
      if (w_mul_now) r_mul_res <= mul_res;
    end
  end

`ifdef MATRIX_CTRL_RX_TIMEOUT_EN
  localparam int GCNT_W = $clog2(RX_GAP_CYC + 1);
  logic [GCNT_W-1:0] r_gap_cnt;

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n)                                                r_gap_cnt <= '0;
    else if (w_state_chg || r_state != LOAD || rx_data_valid)  r_gap_cnt <= '0;
    else                                                       r_gap_cnt <= r_gap_cnt + GCNT_W'(1);
  end

  assign w_gap_expire = (r_state == LOAD) && !rx_data_valid &&
                        (r_gap_cnt == GCNT_W'(RX_GAP_CYC - 1));
`else
  assign w_gap_expire = 1'b0;
`endif

  matrix_byte_ser #(
    .WORD_W (SER_W),
    .CNT_W  (BCNT_W)
  ) u_ser (
    .clk      (sys_clk),
    .rst_n    (rst_n),
    .i_load   (w_ser_load),
    .i_word   (w_ser_word),
    .i_nbytes (w_ser_nbytes),
    .i_ready  (tx_data_ready),
    .o_data   (tx_data),
    .o_valid  (tx_data_valid),
    .o_last   (w_ser_last)
  );

  assign mat_a    = r_mat_a;
  assign mat_b    = r_mat_b;
  assign op_start = r_op_start;
  assign op_sel   = r_op_sel;
  assign busy     = r_busy;
  assign err      = r_err;

endmodule
`default_nettype wire

// File: tb/tb_matrix_op_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_matrix_op_ctrl                                                        |
// | Directed plus randomized command bench with a matrix-arithmetic model.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_matrix_op_ctrl;

  localparam int MB     = 16;
  localparam int MAT_W  = 128;
  localparam int RUN_TO = 4096;
  localparam int GAP    = 64;

  logic             sys_clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [7:0]       rx_data = '0;
  logic             rx_data_valid = 1'b0;
  logic [7:0]       tx_data;
  logic             tx_data_valid;
  logic             tx_data_ready = 1'b0;
  logic [MAT_W-1:0] mat_a, mat_b;
  logic             op_start;
  logic [1:0]       op_sel;
  logic             add_done = 1'b0, mul_done = 1'b0;
  logic [MAT_W-1:0] add_res = '0, mul_res = '0;
  logic             busy, err;

  int n_assert = 0;
  int n_fail   = 0;

  logic [31:0] ma[4], mb[4], radd[4], rmul[4];
  logic [7:0]  exp_q[$];
  logic [7:0]  got_q[$];
  int          tx_cycles;

  always #5 sys_clk = ~sys_clk;

  matrix_op_ctrl #(.N(2), .DW(32), .RUN_TIMEOUT(RUN_TO), .RX_GAP_CYC(GAP)) dut (
    .sys_clk(sys_clk), .rst_n(rst_n), .rx_data(rx_data), .rx_data_valid(rx_data_valid),
    .tx_data(tx_data), .tx_data_valid(tx_data_valid), .tx_data_ready(tx_data_ready),
    .mat_a(mat_a), .mat_b(mat_b), .op_start(op_start), .op_sel(op_sel),
    .add_done(add_done), .mul_done(mul_done), .add_res(add_res), .mul_res(mul_res),
    .busy(busy), .err(err)
  );

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [MAT_W-1:0] pack(input logic [31:0] v[4]);
    logic [MAT_W-1:0] r;
    r = '0;
    for (int e = 0; e < 4; e++) r[(3-e)*32 +: 32] = v[e];
    return r;
  endfunction

  // Reference: element-wise sum and row-by-column product, mod 2^32.
  task automatic model(input logic [1:0] sel);
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++) begin
        radd[i*2+j] = ma[i*2+j] + mb[i*2+j];
        rmul[i*2+j] = ma[i*2]*mb[j] + ma[i*2+1]*mb[2+j];
      end
    exp_q.delete();
    if (sel[0]) for (int e = 0; e < 4; e++) for (int b = 3; b >= 0; b--) exp_q.push_back(8'(radd[e] >> (8*b)));
    if (sel[1]) for (int e = 0; e < 4; e++) for (int b = 3; b >= 0; b--) exp_q.push_back(8'(rmul[e] >> (8*b)));
  endtask

  task automatic rx_byte(input logic [7:0] b);
    rx_data = b;
    rx_data_valid = 1'b1;
    tick();
    rx_data_valid = 1'b0;
  endtask

  task automatic send_operands(input int nbytes, input bit gaps);
    logic [7:0] bytes[$];
    for (int e = 0; e < 4; e++) for (int b = 3; b >= 0; b--) bytes.push_back(8'(ma[e] >> (8*b)));
    for (int e = 0; e < 4; e++) for (int b = 3; b >= 0; b--) bytes.push_back(8'(mb[e] >> (8*b)));
    for (int i = 0; i < nbytes; i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) tick();
      rx_byte(bytes[i]);
    end
  endtask

  task automatic load_cmd(input logic [7:0] opc, input bit gaps);
    rx_byte(opc);
    check("busy_after_opcode", 256'(busy), 256'(1));
    send_operands(2*MB, gaps);
    check("op_start_early", 256'(op_start), 256'(0));
    check("mat_a", 256'(mat_a), 256'(pack(ma)));
    check("mat_b", 256'(mat_b), 256'(pack(mb)));
    tick();
    check("op_start_pulse", 256'(op_start), 256'(1));
    check("op_sel", 256'(op_sel), 256'(opc[1:0]));
  endtask

  // mode 0: ready held high, 1: toggling 1/0, 2: random
  task automatic collect(input int n, input int mode);
    logic       stall_prev;
    logic [7:0] prev;
    logic       rdy;
    got_q.delete();
    stall_prev = 1'b0;
    prev = '0;
    tx_cycles = 0;
    for (int cyc = 0; cyc < n*4 + 20 && got_q.size() < n; cyc++) begin
      if (stall_prev) check("tx_hold", 256'({tx_data_valid, tx_data}), 256'({1'b1, prev}));
      rdy = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
      tx_data_ready = rdy;
      if (tx_data_valid && rdy) got_q.push_back(tx_data);
      stall_prev = tx_data_valid && !rdy;
      prev = tx_data;
      tick();
      tx_cycles++;
    end
    tx_data_ready = 1'b0;
    check("tx_count", 256'(got_q.size()), 256'(n));
    check("tx_valid_drop", 256'(tx_data_valid), 256'(0));
  endtask

  task automatic engine_and_send(input logic [1:0] sel, input int add_lat, input int mul_lat,
                                 input int mode, input string tag);
    int dmax;
    dmax = 0;
    if (sel[0] && add_lat > dmax) dmax = add_lat;
    if (sel[1] && mul_lat > dmax) dmax = mul_lat;
    for (int c = 0; c <= dmax; c++) begin
      add_done = (c == 0) || (sel[0] && c == add_lat) || (!sel[0] && c == 1);
      mul_done = (c == 0) || (sel[1] && c == mul_lat) || (!sel[1] && c == 1);
      if (c == 0) begin
        add_res = ~pack(radd);
        mul_res = ~pack(rmul);
      end
      if (sel[0] && c == add_lat) add_res = pack(radd);
      if (sel[1] && c == mul_lat) mul_res = pack(rmul);
      if (c == 1)    check("op_start_single", 256'(op_start), 256'(0));
      if (c == dmax) check("tx_idle_before_done", 256'(tx_data_valid), 256'(0));
      tick();
    end
    add_done = 1'b0;
    mul_done = 1'b0;
    check("tx_valid_after_done", 256'(tx_data_valid), 256'(1));
    collect(exp_q.size(), mode);
    if (mode == 0) check("throughput", 256'(tx_cycles), 256'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check(tag, 256'(got_q[i]), 256'(exp_q[i]));
    check("busy_after_send", 256'(busy), 256'(0));
  endtask

  task automatic set_seq_operands();
    for (int e = 0; e < 4; e++) begin
      ma[e] = 32'(e + 1);
      mb[e] = 32'(e + 5);
    end
  endtask

  task automatic set_rand_operands();
    for (int e = 0; e < 4; e++) begin
      ma[e] = $urandom;
      mb[e] = $urandom;
    end
  endtask

  initial begin
    int k_err;
    logic [7:0] opc;

    // Reset values
    repeat (3) tick();
    check("rst_tx_data", 256'(tx_data), 256'(0));
    check("rst_tx_valid", 256'(tx_data_valid), 256'(0));
    check("rst_op_start", 256'(op_start), 256'(0));
    check("rst_op_sel", 256'(op_sel), 256'(0));
    check("rst_mats", 256'({mat_a, mat_b}), 256'(0));
    check("rst_busy_err", 256'({busy, err}), 256'(0));
    rst_n = 1'b1;
    tick();

    // Add
    set_seq_operands();
    model(2'b01);
    load_cmd(8'h01, 1'b0);
    engine_and_send(2'b01, 4, 0, 0, "add_byte");

    // Both, multiply finishing 3 cycles before add
    model(2'b11);
    load_cmd(8'h03, 1'b0);
    engine_and_send(2'b11, 5, 2, 0, "both_byte");

    // Bad opcode, then a normal command
    rx_byte(8'h07);
    check("bad_opc_err", 256'(err), 256'(1));
    check("bad_opc_tx", 256'({tx_data_valid, tx_data}), 256'({1'b1, 8'hEE}));
    collect(1, 0);
    check("bad_opc_byte", 256'(got_q.size() > 0 ? got_q[0] : 8'h00), 256'(8'hEE));
    check("bad_opc_busy", 256'(busy), 256'(0));
    model(2'b10);
    load_cmd(8'h02, 1'b0);
    engine_and_send(2'b10, 3, 3, 0, "mul_byte");

    // Backpressure with toggling ready
    set_rand_operands();
    model(2'b11);
    load_cmd(8'h03, 1'b1);
    engine_and_send(2'b11, 2, 6, 1, "bp_byte");

    // Run timeout
    model(2'b10);
    load_cmd(8'h02, 1'b0);
    k_err = -1;
    for (int k = 1; k <= RUN_TO + 10; k++) begin
      tick();
      if (err) begin
        k_err = k;
        break;
      end
    end
    check("run_timeout_cycles", 256'(k_err), 256'(RUN_TO));
    check("run_timeout_tx", 256'({tx_data_valid, tx_data}), 256'({1'b1, 8'hEF}));
    collect(1, 0);
    check("run_timeout_byte", 256'(got_q.size() > 0 ? got_q[0] : 8'h00), 256'(8'hEF));
    check("run_timeout_busy", 256'(busy), 256'(0));

    // Reset after 10 operand bytes
    set_rand_operands();
    rx_byte(8'h03);
    send_operands(10, 1'b0);
    rst_n = 1'b0;
    #2;
    check("mid_rst_outputs", 256'({tx_data_valid, tx_data, op_start, op_sel, busy, err}), 256'(0));
    check("mid_rst_mats", 256'({mat_a, mat_b}), 256'(0));
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_tx_valid", 256'(tx_data_valid), 256'(0));
    set_rand_operands();
    model(2'b11);
    load_cmd(8'h03, 1'b0);
    engine_and_send(2'b11, 3, 4, 2, "post_rst_byte");

`ifdef MATRIX_CTRL_RX_TIMEOUT_EN
    // Operand stall after 5 bytes
    set_rand_operands();
    rx_byte(8'h01);
    send_operands(5, 1'b0);
    k_err = -1;
    for (int k = 1; k <= GAP + 20; k++) begin
      if (err) begin
        k_err = k;
        break;
      end
      tick();
    end
    check("rx_gap_err_seen", 256'(k_err > 0), 256'(1));
    check("rx_gap_tx", 256'({tx_data_valid, tx_data}), 256'({1'b1, 8'hEC}));
    collect(1, 0);
    check("rx_gap_byte", 256'(got_q.size() > 0 ? got_q[0] : 8'h00), 256'(8'hEC));
`endif

    // Randomized commands
    for (int t = 0; t < 6; t++) begin
      opc = 8'($urandom_range(1, 3));
      set_rand_operands();
      model(opc[1:0]);
      load_cmd(opc, 1'b1);
      engine_and_send(opc[1:0], $urandom_range(1, 8), $urandom_range(1, 8),
                      $urandom_range(0, 2), "rand_byte");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/matrix_op_ctrl.md
# matrix_op_ctrl

Byte-stream sequencer placed between the UART receiver/transmitter pair and the 2×2 matrix add and multiply engines. It decodes a one-byte opcode and collects operand matrices A and B big-endian from the RX stream. It then launches the selected engine(s) with a start pulse, waits for completion with a timeout, and serializes the selected result matrices back out through the TX handshake. It replaces the free-running fixed-count receive/send loop with an explicit, error-reporting command flow.

## Interface
- `N`, 2, matrix dimension (N×N elements).
- `DW`, 32, element width in bits; must be a multiple of 8.
- `RUN_TIMEOUT`, 4096, maximum cycles from `op_start` to the required done(s).
- `RX_GAP_CYC`, 2_000_000, maximum idle cycles between operand bytes; used only when `MATRIX_CTRL_RX_TIMEOUT_EN` is defined.
- `sys_clk` in 1: single clock.
- `rst_n` in 1: reset, asynchronous and active-low.
- `rx_data` in 8: received byte.
- `rx_data_valid` in 1: one-cycle strobe marking `rx_data` valid. The receiver is always ready.
- `tx_data` out 8: byte to transmit.
- `tx_data_valid` out 1: `tx_data` is valid.
- `tx_data_ready` in 1: transmitter accepts the byte this cycle.
- `mat_a` out N*N*DW: operand A, row-major, element [0][0] in the MSBs.
- `mat_b` out N*N*DW: operand B, same layout as `mat_a`.
- `op_start` out 1: one-cycle launch pulse to the engines.
- `op_sel` out 2: bit0 selects add, bit1 selects multiply.
- `add_done`, `mul_done` in 1 each: one-cycle completion pulses.
- `add_res`, `mul_res` in N*N*DW each: engine results, same layout as `mat_a`.
- `busy` out 1: high in every state except IDLE.
- `err` out 1: one-cycle pulse on any error.

## Operation
- MB = N*N*DW/8 bytes per matrix.
- A byte is accepted on RX when `rx_data_valid` is high.
- A byte is accepted on TX when `tx_data_valid && tx_data_ready`.
- IDLE:
  - The first accepted RX byte is the opcode: 0x01 = add, 0x02 = multiply, 0x03 = both.
  - A valid opcode latches `op_sel`, clears `mat_a`/`mat_b` and goes to LOAD.
  - Any other opcode pulses `err` and goes to ERR with code 0xEE.
- LOAD:
  - Accepts 2*MB bytes: A first, then B. Within each matrix, bytes run row-major, MSB first per element.
  - Each byte is written directly into its byte lane of the operand bus.
  - After the last byte the block goes to START.
- START: asserts `op_start` for exactly one cycle, then goes to RUN.
- RUN:
  - Latches `add_done`/`mul_done` as sticky flags.
  - When all selected flags are set, goes to SEND.
  - Dones from unselected engines are ignored.
  - If RUN_TIMEOUT cycles elapse first, pulses `err` and goes to ERR with code 0xEF.
- SEND:
  - Transmits the add result (if selected), then the multiply result (if selected). Each is MB bytes in the same byte order as the operands.
  - After the final accepted byte, returns to IDLE.
- ERR: transmits the single error code byte, then returns to IDLE.
- RX bytes arriving in START, RUN, SEND or ERR are discarded.
- `mat_a`/`mat_b` stay stable from START until the next valid opcode.
- `op_sel` stays stable from the opcode until the return to IDLE.
- Byte counter width is clog2(2*MB+1). Counters never wrap; each is reset on every state entry.

## Timing
- Reset values: `tx_data` = 0, `tx_data_valid` = 0, `op_start` = 0, `op_sel` = 0, `mat_a`/`mat_b` = 0, `busy` = 0, `err` = 0. Internal state is IDLE and all counters and flags are 0.
- Reset asserted mid-operation aborts immediately. No partial byte is transmitted after release.
- All outputs are registered.
- Opcode accepted in cycle t → `busy` = 1 in t+1.
- Last operand byte in cycle L → `op_start` = 1 in L+2, and operands are valid from L+1.
- Final required done in cycle D → `tx_data_valid` = 1 with the first byte in D+1. A done arriving in the same cycle as `op_start` is not counted.
- `tx_data_valid` is held with `tx_data` constant until acceptance.
- Accepted in cycle k → the next byte is presented in k+1 with valid still high. Valid drops in the cycle after the last byte is accepted.
- Timeout: `err` pulses in the cycle the counter reaches RUN_TIMEOUT. If a done arrives in that same cycle, the done wins.
- Throughput: one byte per cycle when `tx_data_ready` is held high.

## Configuration
- `MATRIX_CTRL_RX_TIMEOUT_EN` defined:
  - In LOAD, a gap counter resets on every accepted byte.
  - Reaching RX_GAP_CYC pulses `err` and goes to ERR with code 0xEC.
- Not defined: no gap counter is compiled in, and LOAD waits indefinitely.

## Structure
- Package `matrix_ctrl_pkg` holds:
  - the state enum (IDLE, LOAD, START, RUN, SEND, ERR);
  - opcode constants OP_ADD/OP_MUL/OP_BOTH;
  - error codes ERR_OPC = 0xEE, ERR_RUN = 0xEF, ERR_RXGAP = 0xEC;
  - a function computing MB from N and DW.
- One sub-module, `matrix_byte_ser`:
  - loads a width-parameterized word and emits it MSB-first over the valid/ready byte handshake;
  - used for both result transmission and single error bytes.

## Test plan
- Add: opcode 0x01; A = {1,2,3,4}, B = {5,6,7,8} → one `op_start`, `op_sel` = 01; `add_done` returns {6,8,10,12} → 16 TX bytes 00 00 00 06 … 00 00 00 0C.
- Both: opcode 0x03, same operands; `mul_done` 3 cycles before `add_done` → 32 TX bytes, add result first, then {19,22,43,50}.
- Bad opcode 0x07 → `err` pulse, single TX byte 0xEE, `busy` low afterwards; a following valid command works normally.
- TX backpressure: `tx_data_ready` toggled 1/0 → every byte sent exactly once, in order, with `tx_data` stable while unaccepted.
- Run timeout: opcode 0x02, no `mul_done` → `err` exactly RUN_TIMEOUT cycles after `op_start`, TX byte 0xEF.
- Reset asserted after 10 operand bytes → all outputs return to reset values; a fresh full command then gives the correct result. With `MATRIX_CTRL_RX_TIMEOUT_EN`, stalling after 5 operand bytes → TX byte 0xEC.
